// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch queue unit.
package if_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue of {pc, instr} pairs with push/pop/flush.
// Head outputs read as zero while the queue is empty.
module fetch_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [XLEN-1:0]            push_pc,
    input  logic [XLEN-1:0]            push_instr,
    output logic [XLEN-1:0]            head_pc,
    output logic [XLEN-1:0]            head_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [XLEN-1:0] instr_mem_r [DEPTH];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    count_r  <= count_r + CNT_ONE;
                end
                2'b01: begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    count_r  <= count_r - CNT_ONE;
                end
                2'b11: begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    // Entry storage, cleared on reset so no X can ever reach the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= '0;
                instr_mem_r[i] <= '0;
            end
        end else if (push && !flush) begin
            pc_mem_r[wr_ptr_r]    <= push_pc;
            instr_mem_r[wr_ptr_r] <= push_instr;
        end
    end

    assign count      = count_r;
    assign empty      = (count_r == CW'(1'b0));
    assign full       = (count_r == CW'(DEPTH));
    assign head_pc    = empty ? '0 : pc_mem_r[rd_ptr_r];
    assign head_instr = empty ? '0 : instr_mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: single-outstanding memory reads feeding a fetch queue,
// with epoch-based discard of stale reads. Define IF_PERF_EN for fetch/flush counters.
module fetch_queue_unit
    import if_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            JumpD,
    input  logic [XLEN-1:0] PCJumpD,
    input  logic            PCSrcD,
    input  logic [XLEN-1:0] PCBranchD,
    input  logic            StallD,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    output logic            InstrValidF,
    output logic [XLEN-1:0] IRF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic [31:0]     FetchCnt,
    output logic [31:0]     FlushCnt
);
    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_DEPTH = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);

    fetch_state_e    state_r, state_n;
    logic            epoch_r, epoch_n;
    logic            req_epoch_r, req_epoch_n;
    logic [XLEN-1:0] fetch_pc_r, fetch_pc_n;
    logic [XLEN-1:0] req_pc_r, req_pc_n;
    logic            req_s, push_s, pop_s, redirect_s;
    logic [XLEN-1:0] target_s;
    logic [CW-1:0]   fifo_count_s;
    logic            full_s, empty_s;

    assign redirect_s = JumpD | PCSrcD;
    assign target_s   = (JumpD ? PCJumpD : PCBranchD) & ~XLEN'(2'b11);
    assign pop_s      = !empty_s && !StallD && !redirect_s;

    // Fetch state, fetch PC and the epoch the outstanding read was issued under.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            epoch_r     <= 1'b0;
            req_epoch_r <= 1'b0;
            fetch_pc_r  <= RESET_PC;
            req_pc_r    <= '0;
        end else begin
            state_r     <= state_n;
            epoch_r     <= epoch_n;
            req_epoch_r <= req_epoch_n;
            fetch_pc_r  <= fetch_pc_n;
            req_pc_r    <= req_pc_n;
        end
    end

    // Issue/response sequencing. Redirects never issue; a redirect during WAIT
    // marks the read stale once (epoch = ~issue epoch) so repeat redirects stay stale.
    always_comb begin
        state_n     = state_r;
        epoch_n     = epoch_r;
        req_epoch_n = req_epoch_r;
        fetch_pc_n  = fetch_pc_r;
        req_pc_n    = req_pc_r;
        req_s       = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_s) begin
                    fetch_pc_n = target_s;
                end else if (!full_s && !RST) begin
                    req_s       = 1'b1;
                    req_pc_n    = fetch_pc_r;
                    req_epoch_n = epoch_r;
                    fetch_pc_n  = fetch_pc_r + PC_STEP;
                    state_n     = ST_WAIT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (redirect_s) begin
                    fetch_pc_n = target_s;
                    epoch_n    = ~req_epoch_r;
                    if (ImemRvalid) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end else if (ImemRvalid) begin
                    if ((req_epoch_r == epoch_r) && (fifo_count_s < CNT_DEPTH)) begin
                        push_s = 1'b1;
                    end else begin
                        push_s = 1'b0;
                    end
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_s),
        .push_pc    (req_pc_r),
        .push_instr (ImemRdata),
        .head_pc    (PCF),
        .head_instr (IRF),
        .count      (fifo_count_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    assign ImemReq     = req_s;
    assign ImemAddr    = {2'b00, fetch_pc_r[XLEN-1:2]};
    assign InstrValidF = !empty_s;
    assign PCPlus4F    = PCF + PC_STEP;

`ifdef IF_PERF_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] flush_cnt_r;

    // A flush only counts when it throws away a queued or live in-flight instruction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (pop_s) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (redirect_s && (!empty_s || ((state_r == ST_WAIT) && (req_epoch_r == epoch_r)))) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign FetchCnt = fetch_cnt_r;
    assign FlushCnt = flush_cnt_r;
`else
    assign FetchCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule
